// File: rtl/parser_write_buffer_if.sv
// Parser-to-history-buffer write path bundle: literal beats in, write port out.
// Latency: none (wiring only).
// Backpressure: parser_stall toward the parser, wr_valid/wr_ready toward the history buffer.
//
// Ports: data_out/byte_valid/address/valid carry parser beats; wr_* is the
// history-buffer write port; bytes_written and err_* are status outputs.
// master = environment side (parser + history buffer), slave = the buffer block.
interface parser_write_buffer_if;
  logic [63:0] data_out;
  logic [7:0]  byte_valid;
  logic [8:0]  address;
  logic [15:0] valid;
  logic        parser_stall;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_bank;
  logic [8:0]  wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_be;
  logic [31:0] bytes_written;
  logic        err_onehot;
  logic        err_overflow;

  modport master (
    output data_out, byte_valid, address, valid, wr_ready,
    input  parser_stall, wr_valid, wr_bank, wr_addr, wr_data, wr_be,
           bytes_written, err_onehot, err_overflow
  );

  modport slave (
    input  data_out, byte_valid, address, valid, wr_ready,
    output parser_stall, wr_valid, wr_bank, wr_addr, wr_data, wr_be,
           bytes_written, err_onehot, err_overflow
  );
endinterface

// File: rtl/parser_write_buffer.sv
// Queues legal parser literal beats and issues them to the history-buffer write port.
// Latency: 1 cycle from input beat to wr_valid on an empty queue; 1 beat/cycle sustained.
// Backpressure: wr_valid/wr_ready toward history buffer; lookahead parser_stall at occupancy >= STALL_THRESHOLD.
//
// Ports: clk, rst_n (async active-low), bus (parser_write_buffer_if.slave):
//   parser beat inputs, wr_* first-word-fall-through head, byte counter, sticky error flags.
module parser_write_buffer #(
  parameter int FIFO_DEPTH      = 4,
  parameter int STALL_THRESHOLD = 3
) (
  input logic                  clk,
  input logic                  rst_n,
  parser_write_buffer_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0] STALL_C = (PTR_W + 1)'(STALL_THRESHOLD);

  typedef struct packed {
    logic [3:0]  bank;
    logic [8:0]  addr;
    logic [63:0] data;
    logic [7:0]  be;
  } entry_t;

  entry_t           mem_q [FIFO_DEPTH];
  entry_t           mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [31:0]      bytes_q, bytes_d;
  logic             err_onehot_q, err_onehot_d;
  logic             err_overflow_q, err_overflow_d;

  logic             any_valid;
  logic             is_onehot;
  logic             legal;
  logic             push;
  logic             pop;
  logic [3:0]       bank_idx;
  logic [3:0]       be_ones;
  entry_t           head;
  entry_t           beat;

  // Beat classification and bank encode.
  always_comb begin
    any_valid = |bus.valid;
    // x & (x-1) clears the lowest set bit; zero result means at most one bit set.
    is_onehot = any_valid && ((bus.valid & (bus.valid - 16'd1)) == 16'd0);
    legal     = is_onehot && (|bus.byte_valid);
    bank_idx  = '0;
    for (int i = 0; i < 16; i++) begin
      if (bus.valid[i]) bank_idx = 4'(i);
    end
    beat.bank = bank_idx;
    beat.addr = bus.address;
    beat.data = bus.data_out;
    beat.be   = bus.byte_valid;
  end

  // Queue control, counter and flag next-state.
  always_comb begin
    head = mem_q[rd_ptr_q];
    pop  = (count_q != '0) && bus.wr_ready;
    // A full queue still takes a beat when the head leaves in the same cycle.
    push = legal && ((count_q < DEPTH_C) || pop);

    be_ones = '0;
    for (int i = 0; i < 8; i++) begin
      be_ones = be_ones + {3'd0, head.be[i]};
    end

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = beat;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
    bytes_d  = pop ? bytes_q + {28'd0, be_ones} : bytes_q;

    err_onehot_d   = err_onehot_q   || (any_valid && !is_onehot);
    err_overflow_d = err_overflow_q || (legal && !push);
  end

  // Storage is cleared on reset so the wr_* head reads zero when empty after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      bytes_q        <= '0;
      err_onehot_q   <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      bytes_q        <= bytes_d;
      err_onehot_q   <= err_onehot_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  // Outputs come straight from registers; the stall has no combinational input path.
  assign bus.wr_valid      = (count_q != '0);
  assign bus.parser_stall  = (count_q >= STALL_C);
  assign bus.wr_bank       = head.bank;
  assign bus.wr_addr       = head.addr;
  assign bus.wr_data       = head.data;
  assign bus.wr_be         = head.be;
  assign bus.bytes_written = bytes_q;
  assign bus.err_onehot    = err_onehot_q;
  assign bus.err_overflow  = err_overflow_q;

endmodule

// File: tb/tb_parser_write_buffer.sv
// Self-checking bench for parser_write_buffer: directed cases plus randomized traffic.
// Latency: a queue model predicts occupancy; a scoreboard holds expected issued beats.
// Backpressure: wr_ready is driven directly and randomized; parser_stall is honoured in the backpressure case.
module tb_parser_write_buffer;

  localparam int DEPTH = 4;
  localparam int STALL = 3;

  typedef struct packed {
    logic [3:0]  bank;
    logic [8:0]  addr;
    logic [63:0] data;
    logic [7:0]  be;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  parser_write_buffer_if bus();

  parser_write_buffer #(.FIFO_DEPTH(DEPTH), .STALL_THRESHOLD(STALL)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  beat_t       sb_q[$];
  int          m_cnt = 0;
  bit          m_ovf = 0;
  bit          m_onehot = 0;
  logic [31:0] m_bytes = '0;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: at each edge, the queue drains one beat if nonempty and
  // wr_ready, then a legal beat joins if there is room.
  always @(posedge clk) begin : model
    bit pop;
    int ones;
    beat_t b;
    if (rst_n) begin
      pop  = (m_cnt != 0) && (bus.wr_ready === 1'b1);
      ones = $countones(bus.valid);
      if (ones > 1) m_onehot = 1;
      if (pop) m_cnt--;
      if (ones == 1 && bus.byte_valid != 8'h00) begin
        if (m_cnt < DEPTH) begin
          b.bank = 4'($clog2(bus.valid));
          b.addr = bus.address;
          b.data = bus.data_out;
          b.be   = bus.byte_valid;
          sb_q.push_back(b);
          m_cnt++;
        end else begin
          m_ovf = 1;
        end
      end
    end
  end

  // Monitor: status checks every cycle, head checks on every handshake.
  always @(negedge clk) begin : monitor
    beat_t got, exp;
    if (rst_n) begin
      chk("wr_valid", 96'(bus.wr_valid), 96'(m_cnt != 0));
      chk("parser_stall", 96'(bus.parser_stall), 96'(m_cnt >= STALL));
      chk("err_onehot", 96'(bus.err_onehot), 96'(m_onehot));
      chk("err_overflow", 96'(bus.err_overflow), 96'(m_ovf));
      chk("bytes_written", 96'(bus.bytes_written), 96'(m_bytes));
      if (bus.wr_valid === 1'b1 && bus.wr_ready === 1'b1) begin
        got = {bus.wr_bank, bus.wr_addr, bus.wr_data, bus.wr_be};
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: got %0h expected none", got);
        end else begin
          exp = sb_q.pop_front();
          chk("wr_beat", 96'(got), 96'(exp));
          m_bytes = m_bytes + 32'($countones(exp.be));
        end
      end
    end
  end

  // All drive tasks are entered and left 1 time unit after a rising edge.
  task automatic drive(input logic [15:0] v, input logic [7:0] bv, input logic [8:0] a,
                       input logic [63:0] d, input logic rdy);
    bus.valid      = v;
    bus.byte_valid = bv;
    bus.address    = a;
    bus.data_out   = d;
    bus.wr_ready   = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) drive(16'h0, 8'h00, 9'h0, 64'h0, rdy);
  endtask

  task automatic send(input int bank, input logic rdy);
    logic [15:0] v;
    v = 16'h0001 << bank;
    drive(v, 8'(($urandom_range(1, 255))), 9'($urandom), {$urandom, $urandom}, rdy);
  endtask

  task automatic reset_now();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wr_valid", 96'(bus.wr_valid), 96'd0);
    chk("rst_stall", 96'(bus.parser_stall), 96'd0);
    chk("rst_bytes", 96'(bus.bytes_written), 96'd0);
    chk("rst_err_onehot", 96'(bus.err_onehot), 96'd0);
    chk("rst_err_overflow", 96'(bus.err_overflow), 96'd0);
    chk("rst_head", 96'({bus.wr_bank, bus.wr_addr, bus.wr_data, bus.wr_be}), 96'd0);
    sb_q.delete();
    m_cnt    = 0;
    m_ovf    = 0;
    m_onehot = 0;
    m_bytes  = '0;
    bus.valid    = '0;
    bus.wr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [63:0] first_data;
    int          sent;
    int          cyc;
    bit          prev_stall;
    bit          stall;
    logic [15:0] v;

    bus.valid = '0; bus.byte_valid = '0; bus.address = '0; bus.data_out = '0; bus.wr_ready = 1'b0;
    @(posedge clk);
    #1;
    reset_now();

    // Single beat.
    drive(16'h0001, 8'hc0, 9'h000, {16'h0d0a, 48'h0}, 1'b1);
    chk("single_valid", 96'(bus.wr_valid), 96'd1);
    chk("single_bank", 96'(bus.wr_bank), 96'd0);
    chk("single_be", 96'(bus.wr_be), 96'hc0);
    chk("single_data", 96'(bus.wr_data[63:48]), 96'h0d0a);
    idle(1'b1, 1);
    chk("single_bytes", 96'(bus.bytes_written), 96'd2);

    // Bank encode walk.
    reset_now();
    for (int k = 0; k < 16; k++) begin
      v = 16'h0001 << k;
      drive(v, 8'hff, 9'(k), {$urandom, $urandom}, 1'b1);
    end
    idle(1'b1, 3);
    chk("walk_bytes", 96'(bus.bytes_written), 96'd128);

    // Backpressure with a parser that obeys the stall.
    reset_now();
    sent = 0; cyc = 0; prev_stall = 0; first_data = '0;
    while (sent < 4 && cyc < 20) begin
      stall = bus.parser_stall;
      if (!stall || !prev_stall) begin
        if (sent == 0) begin
          first_data = 64'h1111_2222_3333_4444;
          drive(16'h0020, 8'hff, 9'h011, first_data, 1'b0);
        end else begin
          send(sent, 1'b0);
        end
        sent++;
      end else begin
        idle(1'b0, 1);
      end
      prev_stall = stall;
      cyc++;
    end
    chk("bp_sent", 96'(sent), 96'd4);
    idle(1'b0, 2);
    chk("bp_stall", 96'(bus.parser_stall), 96'd1);
    chk("bp_no_overflow", 96'(bus.err_overflow), 96'd0);
    chk("bp_head_data", 96'(bus.wr_data), 96'(first_data));
    chk("bp_head_bank", 96'(bus.wr_bank), 96'd5);
    idle(1'b1, 6);
    chk("bp_drained", 96'(bus.wr_valid), 96'd0);

    // Overflow: fill, push+pop while full, then drop a beat.
    reset_now();
    for (int k = 0; k < 4; k++) send(k, 1'b0);
    send(7, 1'b1);
    chk("full_pushpop_no_err", 96'(bus.err_overflow), 96'd0);
    send(8, 1'b0);
    chk("ovf_flag", 96'(bus.err_overflow), 96'd1);
    idle(1'b1, 6);
    chk("ovf_sticky", 96'(bus.err_overflow), 96'd1);
    chk("ovf_drained", 96'(sb_q.size()), 96'd0);

    // Malformed beats.
    reset_now();
    drive(16'h0003, 8'hff, 9'h001, 64'hdead, 1'b1);
    drive(16'h0004, 8'h00, 9'h002, 64'hbeef, 1'b1);
    chk("mal_onehot", 96'(bus.err_onehot), 96'd1);
    idle(1'b1, 3);
    chk("mal_nothing_queued", 96'(bus.wr_valid), 96'd0);
    chk("mal_onehot_sticky", 96'(bus.err_onehot), 96'd1);
    chk("mal_no_overflow", 96'(bus.err_overflow), 96'd0);

    // Reset mid-stream with two beats queued.
    send(2, 1'b0);
    send(3, 1'b0);
    chk("mid_two_queued", 96'(bus.wr_valid), 96'd1);
    reset_now();

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 5)       v = 16'h0001 << $urandom_range(0, 15);
      else if (r == 5) v = 16'(($urandom | 32'h3) << $urandom_range(0, 14));
      else             v = 16'h0;
      drive(v, ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
            9'($urandom), {$urandom, $urandom}, 1'($urandom_range(0, 3) != 0));
    end
    idle(1'b1, 8);
    chk("final_drained", 96'(sb_q.size()), 96'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
